demux2_32_buf: RTL and testbench
================================

// Module: demux2_32_buf
// PURPOSE
//   Registered 1-to-2 demultiplexer: the steering counterpart of mux2_32. Routes a
//   32-bit word from a single producer to one of two consumers, selected by S0.
//   Each output side has a 2-entry FIFO with valid/ready handshake, so a stalled
//   consumer never blocks traffic to the other side. Each side also keeps a
//   wrapping count of accepted words. Sits between a producer stage and two
//   downstream pipeline stages.
// PARAMETERS
//   W   32  data width of IN, Y0, Y1
//   CW  8   width of the per-side accepted-word counters CNT0/CNT1
// PORTS
//   CLK    in   1    clock; all state updates on the rising edge
//   CLR    in   1    asynchronous, active-low reset
//   IN     in   W    input data word
//   IN_V   in   1    IN is valid this cycle
//   S0     in   1    destination select: 0 -> side 0 (Y0), 1 -> side 1 (Y1)
//   IN_R   out  1    block accepts IN this cycle (combinational)
//   Y0     out  W    side-0 FIFO head data
//   Y0_V   out  1    side-0 FIFO non-empty
//   Y0_R   in   1    side-0 consumer ready
//   Y1     out  W    side-1 FIFO head data
//   Y1_V   out  1    side-1 FIFO non-empty
//   Y1_R   in   1    side-1 consumer ready
//   CNT0   out  CW   words accepted for side 0, wraps modulo 2^CW
//   CNT1   out  CW   words accepted for side 1, wraps modulo 2^CW
// BEHAVIOUR
//   Reset (CLR=0, async, takes effect immediately):
//     - both FIFOs empty; Y0_V=Y1_V=0; Y0=Y1=0; CNT0=CNT1=0
//     - in-flight words are discarded
//   Per-side state: 2-entry FIFO; occupancy count in {0,1,2}.
//   Ready:
//     - IN_R = (occupancy of side S0) < 2
//     - depends only on S0 and registered occupancy, never on Y*_R
//     - a full side does not accept input even when it pops in the same cycle
//   Push: on IN_V & IN_R, write IN into the tail of FIFO[S0] and increment CNT[S0].
//     - CNTn = 2^CW-1 followed by an accept wraps to 0
//     - the unselected side and its counter are unchanged
//   Pop: on Yn_V & Yn_R, remove the head of side n; the next entry becomes Yn.
//   Push and pop on the same side in one cycle: occupancy unchanged, order preserved.
//   Latency: a word accepted at edge k appears on Yn with Yn_V=1 after edge k
//     if that side was empty. No combinational path from IN to Yn.
//   Order: strict FIFO per side. There is no ordering relation between the sides.
//   Yn holds its value while Yn_V=1 and Yn_R=0.
//   When Yn_V=0, Yn holds its last value (0 after reset).
//   IN_V=0: no state change on the push side. IN_R remains defined and reflects S0.
//   Words are never dropped or duplicated; overflow is impossible by construction.
// TESTING
//   1 Reset: drive CLR=0 mid-traffic with both sides holding data
//     -> Y0_V=Y1_V=0, Y0=Y1=0, CNT0=CNT1=0 immediately, without waiting for a CLK edge.
//   2 Steer: IN=AAAAAAAA, S0=0, IN_V=1, one cycle
//     -> next cycle Y0=AAAAAAAA, Y0_V=1, CNT0=1, Y1_V=0.
//     Then IN=55555555, S0=1
//     -> Y1=55555555, CNT1=1.
//   3 Backpressure: Y0_R=0; push 11111111 then 22222222 to side 0
//     -> IN_R=0 while S0=0, IN_R=1 while S0=1.
//     Then raise Y0_R -> Y0 presents 11111111, then 22222222.
//   4 Full plus pop: side 0 full, Y0_R=1, IN_V=1, S0=0
//     -> IN_R=0 that cycle.
//     Next cycle occupancy=1 and IN_R=1.
//     Simultaneous push+pop at occupancy 1 keeps Y0_V=1 and preserves order.
//   5 Wrap: accept 256 words to side 1 (CW=8)
//     -> CNT1 goes 255 then 0; CNT0 unchanged.
//   6 Random: 1000 cycles of random IN/S0/IN_V/Y0_R/Y1_R checked against a queue model
//     -> every word exits on the correct side, in order, exactly once.

Source files
------------

// File: rtl/demux2_32_buf.sv
// Registered 1-to-2 demultiplexer: steers one producer's words into two independent
// 2-entry output FIFOs with valid/ready handshakes and per-side accepted-word counters.
module demux2_32_buf #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic [W-1:0]  IN,
  input  logic          IN_V,
  input  logic          S0,
  output logic          IN_R,
  output logic [W-1:0]  Y0,
  output logic          Y0_V,
  input  logic          Y0_R,
  output logic [W-1:0]  Y1,
  output logic          Y1_V,
  input  logic          Y1_R,
  output logic [CW-1:0] CNT0,
  output logic [CW-1:0] CNT1
);

  // Each side: head register drives Yn directly, second register holds the tail.
  logic [W-1:0]  head_q [2];
  logic [W-1:0]  head_d [2];
  logic [W-1:0]  tail_q [2];
  logic [W-1:0]  tail_d [2];
  logic [1:0]    occ_q  [2];
  logic [1:0]    occ_d  [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];

  logic       in_r;
  logic [1:0] sel;
  logic [1:0] out_r;
  logic [1:0] push;
  logic [1:0] pop;

  assign sel   = {S0, ~S0};
  assign out_r = {Y1_R, Y0_R};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    in_r = (occ_q[S0] != 2'd2);
    for (int s = 0; s < 2; s++) begin
      head_d[s] = head_q[s];
      tail_d[s] = tail_q[s];
      push[s]   = IN_V && in_r && sel[s];
      pop[s]    = (occ_q[s] != 2'd0) && out_r[s];

      if (pop[s] && occ_q[s] == 2'd2)
        head_d[s] = tail_q[s];

      // A push lands in the head slot whenever the head is (or is about to be) free.
      if (push[s]) begin
        if (occ_q[s] == 2'd0 || pop[s])
          head_d[s] = IN;
        else
          tail_d[s] = IN;
      end

      occ_d[s] = occ_q[s] + {1'b0, push[s]} - {1'b0, pop[s]};
      cnt_d[s] = cnt_q[s] + CW'(push[s]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int s = 0; s < 2; s++) begin
        head_q[s] <= '0;
        tail_q[s] <= '0;
        occ_q[s]  <= '0;
        cnt_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        head_q[s] <= head_d[s];
        tail_q[s] <= tail_d[s];
        occ_q[s]  <= occ_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
    end
  end

  assign IN_R = in_r;
  assign Y0   = head_q[0];
  assign Y1   = head_q[1];
  assign Y0_V = (occ_q[0] != 2'd0);
  assign Y1_V = (occ_q[1] != 2'd0);
  assign CNT0 = cnt_q[0];
  assign CNT1 = cnt_q[1];

endmodule

// File: tb/tb_demux2_32_buf.sv
// Self-checking bench for demux2_32_buf: directed scenarios plus random traffic,
// all compared against a queue-based model of the two output FIFOs.
module tb_demux2_32_buf;

  logic        CLK;
  logic        CLR;
  logic [31:0] IN;
  logic        IN_V;
  logic        S0;
  logic        IN_R;
  logic [31:0] Y0;
  logic        Y0_V;
  logic        Y0_R;
  logic [31:0] Y1;
  logic        Y1_V;
  logic        Y1_R;
  logic [7:0]  CNT0;
  logic [7:0]  CNT1;

  demux2_32_buf #(.W(32), .CW(8)) dut (
    .CLK(CLK), .CLR(CLR), .IN(IN), .IN_V(IN_V), .S0(S0), .IN_R(IN_R),
    .Y0(Y0), .Y0_V(Y0_V), .Y0_R(Y0_R),
    .Y1(Y1), .Y1_V(Y1_V), .Y1_R(Y1_R),
    .CNT0(CNT0), .CNT1(CNT1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per side, modular counters, last shown head word.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          m_cnt0, m_cnt1;
  logic [31:0] last0, last1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
    last0  = '0;
    last1  = '0;
  endtask

  task automatic check_outputs();
    if (q0.size() > 0) last0 = q0[0];
    if (q1.size() > 0) last1 = q1[0];
    check("y0_v", 32'(Y0_V), 32'(q0.size() > 0));
    check("y1_v", 32'(Y1_V), 32'(q1.size() > 0));
    check("y0",   Y0, last0);
    check("y1",   Y1, last1);
    check("cnt0", 32'(CNT0), 32'(m_cnt0));
    check("cnt1", 32'(CNT1), 32'(m_cnt1));
  endtask

  // One clock cycle: drive inputs, check IN_R before the edge, advance model and DUT, check outputs.
  task automatic cycle(input logic [31:0] d, input logic s, input logic v,
                       input logic r0, input logic r1);
    logic acc_r, pop0, pop1;
    IN = d; S0 = s; IN_V = v; Y0_R = r0; Y1_R = r1;
    #1;
    acc_r = s ? (q1.size() < 2) : (q0.size() < 2);
    check("in_r", 32'(IN_R), 32'(acc_r));
    pop0 = (q0.size() > 0) && r0;
    pop1 = (q1.size() > 0) && r1;
    @(posedge CLK);
    #1;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (v && acc_r) begin
      if (s) begin q1.push_back(d); m_cnt1 = (m_cnt1 + 1) % 256; end
      else   begin q0.push_back(d); m_cnt0 = (m_cnt0 + 1) % 256; end
    end
    check_outputs();
  endtask

  task automatic async_reset();
    CLR = 1'b0;
    #1;
    model_reset();
    check("rst_y0_v", 32'(Y0_V), 32'd0);
    check("rst_y1_v", 32'(Y1_V), 32'd0);
    check("rst_y0",   Y0, 32'd0);
    check("rst_y1",   Y1, 32'd0);
    check("rst_cnt0", 32'(CNT0), 32'd0);
    check("rst_cnt1", 32'(CNT1), 32'd0);
    #1;
    CLR = 1'b1;
  endtask

  initial begin
    model_reset();
    CLR = 1'b0; IN = '0; IN_V = 1'b0; S0 = 1'b0; Y0_R = 1'b0; Y1_R = 1'b0;
    #2;
    check_outputs();
    #10;
    CLR = 1'b1;

    // Steer one word to each side.
    cycle(32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 1'b0);
    check("steer_y0", Y0, 32'hAAAAAAAA);
    check("steer_cnt0", 32'(CNT0), 32'd1);
    check("steer_y1_v", 32'(Y1_V), 32'd0);
    cycle(32'h55555555, 1'b1, 1'b1, 1'b0, 1'b0);
    check("steer_y1", Y1, 32'h55555555);
    check("steer_cnt1", 32'(CNT1), 32'd1);

    // Reset in the middle of traffic with both sides holding data, away from any edge.
    #2;
    async_reset();

    // Backpressure on side 0.
    cycle(32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_in_r_s0", 32'(IN_R), 32'd0);
    cycle(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_head", Y0, 32'h11111111);
    IN_V = 1'b0; S0 = 1'b1; #1;
    check("bp_in_r_s1", 32'(IN_R), 32'd1);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_second", Y0, 32'h22222222);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_drained", 32'(Y0_V), 32'd0);
    check("bp_hold", Y0, 32'h22222222);

    // Full side popping in the same cycle still refuses input.
    cycle(32'h33333333, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(32'h44444444, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(32'h55555555, 1'b0, 1'b1, 1'b1, 1'b0);
    check("full_pop_head", Y0, 32'h44444444);
    cycle(32'h66666666, 1'b0, 1'b1, 1'b1, 1'b0);
    check("pushpop_v", 32'(Y0_V), 32'd1);
    check("pushpop_head", Y0, 32'h66666666);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Side-1 counter wrap.
    #2;
    async_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(32'(i), 1'b1, 1'b1, 1'b0, 1'b1);
      if (i == 254) check("wrap_255", 32'(CNT1), 32'd255);
    end
    check("wrap_0", 32'(CNT1), 32'd0);
    check("wrap_cnt0", 32'(CNT0), 32'd0);

    // Random traffic.
    for (int i = 0; i < 1000; i++)
      cycle($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    // Drain both sides and confirm nothing was left or invented.
    for (int i = 0; i < 4; i++)
      cycle(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("drain_y0_v", 32'(Y0_V), 32'd0);
    check("drain_y1_v", 32'(Y1_V), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
